rr_burst_mux: RTL and testbench

Downstream consumer of the 4-requester round-robin arbiter. It presents per-channel valid as the arbiter request vector, captures the one-hot grant, and locks the granted channel for a whole multi-beat burst. During the burst it freezes the arbiter by withdrawing all requests, then forwards beats through a registered valid/ready output stage to the shared link. Bursts longer than a configured limit are truncated.

---
 rtl/rr_burst_mux.sv | 106 ++++++++++
 tb/tb_rr_burst_mux.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_burst_mux.sv
// Burst-locking consumer of a 4-way round-robin arbiter: captures the grant, holds the
// owner for a whole burst (truncated at MAX_BEATS) and forwards beats through a registered stage.
module rr_burst_mux #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            ch_valid,
  input  logic [4*DATA_W-1:0]   ch_data,
  input  logic [3:0]            ch_last,
  output logic [3:0]            ch_ready,
  output logic [3:0]            arb_req,
  input  logic [3:0]            arb_gnt,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_last,
  output logic [1:0]            out_id,
  input  logic                  out_ready,
  output logic                  err_trunc
);

  localparam int unsigned        CNT_W    = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(MAX_BEATS - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t              state, state_nx;
  logic [1:0]          owner, gnt_idx;
  logic                gnt_found;
  logic [CNT_W-1:0]    beat_cnt;
  logic [DATA_W-1:0]   owner_data;
  logic                slot_free, accept, at_limit, cap_last;

  // Lowest set grant bit wins if the arbiter ever returns a multi-hot grant.
  always_comb begin
    gnt_idx   = '0;
    gnt_found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (arb_gnt[i] && !gnt_found) begin
        gnt_idx   = 2'(i);
        gnt_found = 1'b1;
      end
    end
  end

  always_comb begin
    owner_data = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (owner == 2'(i)) owner_data = ch_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_nx  = state;
    arb_req   = '0;
    ch_ready  = '0;
    accept    = 1'b0;
    slot_free = out_ready | ~out_valid;
    at_limit  = (beat_cnt == LAST_CNT);
    cap_last  = ch_last[owner] | at_limit;
    case (state)
      IDLE: begin
        arb_req = ch_valid;
        if (gnt_found) state_nx = BURST;
      end
      BURST: begin
        // Requests stay withdrawn for the whole burst so the arbiter mask is frozen.
        ch_ready[owner] = slot_free;
        accept          = ch_valid[owner] & slot_free;
        if (accept && cap_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= '0;
      beat_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_id    <= '0;
      err_trunc <= 1'b0;
    end else begin
      state     <= state_nx;
      err_trunc <= accept & ~ch_last[owner] & at_limit;
      if (state == IDLE && gnt_found) begin
        owner    <= gnt_idx;
        beat_cnt <= '0;
      end
      if (accept) begin
        beat_cnt  <= beat_cnt + CNT_W'(1);
        out_valid <= 1'b1;
        out_data  <= owner_data;
        out_last  <= cap_last;
        out_id    <= owner;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_burst_mux.sv
// Scoreboard bench for rr_burst_mux: a round-robin arbiter model feeds the grant, per-channel
// beat queues drive the inputs, and a burst-level reference model predicts the output stream.
module tb_rr_burst_mux;

  localparam int DW = 32;
  localparam int MB = 4;

  logic              clk, rst_n;
  logic [3:0]        ch_valid, ch_last, ch_ready, arb_req, arb_gnt;
  logic [4*DW-1:0]   ch_data;
  logic              out_valid, out_last, out_ready, err_trunc;
  logic [DW-1:0]     out_data;
  logic [1:0]        out_id;

  rr_burst_mux #(.DATA_W(DW), .MAX_BEATS(MB)) dut (
    .clk(clk), .rst_n(rst_n), .ch_valid(ch_valid), .ch_data(ch_data), .ch_last(ch_last),
    .ch_ready(ch_ready), .arb_req(arb_req), .arb_gnt(arb_gnt), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .out_id(out_id), .out_ready(out_ready),
    .err_trunc(err_trunc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Round-robin arbiter environment: search starts at arb_ptr, pointer moves past the winner.
  logic [1:0] arb_ptr, gidx, ac;
  logic       gfound;
  always_comb begin
    arb_gnt = '0;
    gidx    = '0;
    gfound  = 1'b0;
    ac      = '0;
    for (int k = 0; k < 4; k++) begin
      ac = arb_ptr + 2'(k);
      if (!gfound && arb_req[ac]) begin
        arb_gnt[ac] = 1'b1;
        gidx        = ac;
        gfound      = 1'b1;
      end
    end
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)      arb_ptr <= '0;
    else if (gfound) arb_ptr <= gidx + 2'd1;
  end

  typedef struct packed { logic [DW-1:0] data; logic last; } beat_t;
  typedef struct packed { logic [DW-1:0] data; logic last; logic [1:0] id; logic trunc; } exp_t;

  beat_t drv_q[4][$];
  beat_t mdl_q[4][$];
  exp_t  exp_q[$];
  int    m_ptr = 0;

  int n_vec = 0, n_fail = 0;
  int trunc_seen = 0, exp_trunc = 0;
  int cyc = 0, last_hs = -1;
  bit rate_chk = 0, gap_en = 0;
  int rdy_mode = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add_burst(input int ch, input int n, input logic [DW-1:0] base);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.data = base + DW'(k);
      b.last = (k == n - 1);
      drv_q[ch].push_back(b);
      mdl_q[ch].push_back(b);
    end
  endtask

  // Burst-level reference: pick the next non-empty channel round-robin, emit up to MB beats.
  task automatic model_run();
    int    c, n;
    bit    done;
    beat_t b;
    exp_t  e;
    forever begin
      c = -1;
      for (int k = 0; k < 4; k++)
        if (c < 0 && mdl_q[(m_ptr + k) % 4].size() > 0) c = (m_ptr + k) % 4;
      if (c < 0) break;
      n    = 0;
      done = 0;
      while (!done && mdl_q[c].size() > 0) begin
        b       = mdl_q[c].pop_front();
        n++;
        e.data  = b.data;
        e.id    = 2'(c);
        e.trunc = !b.last && (n == MB);
        e.last  = b.last || (n == MB);
        exp_q.push_back(e);
        done    = e.last;
      end
      m_ptr = (c + 1) % 4;
    end
  endtask

  function automatic bit pending();
    bit p = (exp_q.size() != 0);
    for (int i = 0; i < 4; i++) if (drv_q[i].size() != 0) p = 1;
    return p;
  endfunction

  task automatic wait_drain(input int budget);
    int t = 0;
    while (pending() && t < budget) begin
      @(posedge clk);
      t++;
    end
    chk("drain_timeout", 64'(t >= budget), 64'd0);
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic random_multi(input int phases);
    for (int p = 0; p < phases; p++) begin
      for (int ch = 0; ch < 4; ch++) begin
        int nb = $urandom_range(0, 3);
        for (int b = 0; b < nb; b++) add_burst(ch, $urandom_range(1, 7), $urandom);
      end
      model_run();
      wait_drain(3000);
    end
  endtask

  // Input driver: pops beats the DUT accepted, presents queue heads, sets out_ready.
  initial begin
    logic [3:0] acc;
    ch_valid  = '0;
    ch_data   = '0;
    ch_last   = '0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      acc = ch_valid & ch_ready;
      @(posedge clk);
      #1;
      if (rst_n)
        for (int i = 0; i < 4; i++)
          if (acc[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
      for (int i = 0; i < 4; i++) begin
        if (drv_q[i].size() > 0) begin
          ch_data[i*DW +: DW] = drv_q[i][0].data;
          ch_last[i]          = drv_q[i][0].last;
          ch_valid[i]         = !(gap_en && $urandom_range(0, 2) == 0);
        end else begin
          ch_valid[i] = 1'b0;
          ch_last[i]  = 1'b0;
        end
      end
      out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? ($urandom_range(0, 9) < 7) : 1'b0;
    end
  end

  // Monitor: protocol checks every cycle, scoreboard compare on each output handshake.
  initial begin
    logic pv, pr, pl;
    logic [DW-1:0] pd;
    logic [1:0] pi;
    exp_t e;
    pv = 0; pr = 1; pl = 0; pd = '0; pi = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        pv = 0;
      end else begin
        chk("ch_ready_onehot0", 64'($onehot0(ch_ready)), 64'd1);
        chk("req_vs_ready", 64'((arb_req == 4'd0) || (arb_req == ch_valid && ch_ready == 4'd0)), 64'd1);
        if (pv && !pr) begin
          chk("hold_valid", 64'(out_valid), 64'd1);
          chk("hold_data", 64'(out_data), 64'(pd));
          chk("hold_last", 64'(out_last), 64'(pl));
          chk("hold_id", 64'(out_id), 64'(pi));
        end
        if (out_valid && !out_ready) chk("stall_ready", 64'(ch_ready), 64'd0);
        if (err_trunc) begin
          trunc_seen++;
          chk("trunc_on_trunc_beat",
              64'(out_valid && exp_q.size() > 0 && exp_q[0].trunc), 64'd1);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 64'(out_data), 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", 64'(out_data), 64'(e.data));
            chk("out_last", 64'(out_last), 64'(e.last));
            chk("out_id", 64'(out_id), 64'(e.id));
            if (e.trunc) exp_trunc++;
          end
          if (rate_chk) begin
            if (last_hs >= 0) chk("beat_spacing", 64'(cyc - last_hs), 64'd2);
            last_hs = cyc;
          end
        end
        pv = out_valid; pr = out_ready; pd = out_data; pl = out_last; pi = out_id;
      end
    end
  end

  initial begin
    int t;
    rst_n = 1'b0;
    rdy_mode = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_out_id", 64'(out_id), 64'd0);
    chk("rst_err_trunc", 64'(err_trunc), 64'd0);
    chk("rst_ch_ready", 64'(ch_ready), 64'd0);
    chk("rst_arb_req", 64'(arb_req), 64'(ch_valid));
    rst_n = 1'b1;

    // Directed 3-beat burst on channel 2: cycle-exact handshake timing.
    @(posedge clk); #2;
    add_burst(2, 3, 32'hD000_0000);
    model_run();
    @(posedge clk); #2;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("dir_arb_req", 64'(arb_req), (k == 0) ? 64'h4 : 64'h0);
      chk("dir_ch_ready", 64'(ch_ready), (k >= 1 && k <= 3) ? 64'h4 : 64'h0);
      chk("dir_out_valid", 64'(out_valid), 64'(k >= 2 && k <= 4));
      if (k >= 2 && k <= 4) chk("dir_out_id", 64'(out_id), 64'd2);
    end
    wait_drain(200);

    // Single-beat bursts on all channels: one output beat every 2 cycles.
    rate_chk = 1;
    last_hs  = -1;
    for (int r = 0; r < 3; r++)
      for (int ch = 0; ch < 4; ch++) add_burst(ch, 1, 32'hA000_0000 + 32'(r * 16 + ch));
    model_run();
    wait_drain(400);
    rate_chk = 0;

    // Random traffic with backpressure.
    rdy_mode = 1;
    @(posedge clk); #2;
    random_multi(6);

    // Single channel with valid gaps, including a 6-beat burst that truncates.
    gap_en = 1;
    add_burst(1, 6, 32'hB000_0000);
    add_burst(1, 2, 32'hB100_0000);
    model_run();
    wait_drain(1000);
    gap_en = 0;

    // Reset while a beat is stalled in the output register.
    rdy_mode = 2;
    @(posedge clk); @(posedge clk); #2;
    add_burst(0, 8, 32'hC000_0000);
    model_run();
    t = 0;
    while (!out_valid && t < 20) begin
      @(posedge clk); #2;
      t++;
    end
    chk("stall_reached", 64'(out_valid), 64'd1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_ch_ready", 64'(ch_ready), 64'd0);
    chk("mid_rst_arb_req", 64'(arb_req), 64'(ch_valid));
    chk("mid_rst_req_nonzero", 64'(arb_req), 64'h1);
    repeat (2) @(posedge clk);
    #2;
    for (int i = 0; i < 4; i++) begin
      drv_q[i].delete();
      mdl_q[i].delete();
    end
    exp_q.delete();
    m_ptr = 0;
    @(posedge clk); #2;
    @(negedge clk);
    rst_n    = 1'b1;
    rdy_mode = 1;
    @(posedge clk); #2;
    random_multi(3);

    chk("trunc_pulse_count", 64'(trunc_seen), 64'(exp_trunc));
    chk("trunc_exercised", 64'(exp_trunc > 0), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
